// File: rtl/fnd_pkg.sv
// Shared types and constants for the 4-digit FND scanner.
// Slot length is derived here so the top and the timer agree on it.
package fnd_pkg;

  typedef enum logic {
    ST_BLANK   = 1'b0,
    ST_DISPLAY = 1'b1
  } scanState_t;

  localparam int DIGIT_COUNT = 4;
  localparam int POS_W       = 2;
  localparam int NIBBLE_W    = 4;

  function automatic int slotCycles(input int clkFreqHz, input int scanHz);
    return clkFreqHz / scanHz;
  endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// Counts cycles within the current scan phase and flags the last one.
// The count restarts whenever the last cycle is reached, which is exactly when the phase changes.
module fnd_slot_timer #(
  parameter int BLANK_LEN   = 1000,
  parameter int DISPLAY_LEN = 99000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_displaySel,
  output logic o_lastCycle
);

  localparam int MAX_LEN = (BLANK_LEN > DISPLAY_LEN) ? BLANK_LEN : DISPLAY_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  // A zero-length blank phase is treated as a single cycle that ends immediately.
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'((BLANK_LEN == 0) ? 0 : BLANK_LEN - 1);
  localparam logic [CNT_W-1:0] DISPLAY_LAST = CNT_W'(DISPLAY_LEN - 1);

  logic [CNT_W-1:0] slotCnt;

  assign o_lastCycle = (slotCnt == (i_displaySel ? DISPLAY_LAST : BLANK_LAST));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slotCnt <= '0;
    end else if (o_lastCycle) begin
      slotCnt <= '0;
    end else begin
      slotCnt <= slotCnt + 1'b1;
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed scanner for a 4-digit FND: blank gap, then display, per position.
// The displayed word is swapped only when the position wraps 3->0, so frames never mix data.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_SUPPRESS  = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic [NIBBLE_W*DIGIT_COUNT-1:0] i_value,
  input  logic [DIGIT_COUNT-1:0]        i_dpMask,
  input  logic [DIGIT_COUNT-1:0]        i_digitEn,
  input  logic                          i_load,
  output logic [POS_W-1:0]              o_digitPosion,
  output logic [NIBBLE_W-1:0]           o_digitValue,
  output logic                          o_dp,
  output logic                          o_blank,
  output logic                          o_frameStart
);

  localparam int SLOT           = slotCycles(CLK_FREQ_HZ, SCAN_HZ);
  localparam int DISPLAY_CYCLES = SLOT - BLANK_CYCLES;
  localparam int WORD_W         = NIBBLE_W * DIGIT_COUNT;

  if (BLANK_CYCLES < 0 || BLANK_CYCLES > SLOT - 1) begin : gBadBlank
    $error("fnd_scan_controller: BLANK_CYCLES out of range 0..SLOT-1");
  end

  scanState_t             state, stateNext;
  logic [POS_W-1:0]       pos, posNext;
  logic                   lastCycle, advance, wrap;
  logic [WORD_W-1:0]      pendValue, shadowValue, shadowValueNext;
  logic [DIGIT_COUNT-1:0] pendDp, shadowDp, shadowDpNext;
  logic [DIGIT_COUNT-1:0] pendEn, shadowEn, shadowEnNext;
  logic [DIGIT_COUNT-1:0] supNext;

  fnd_slot_timer #(
    .BLANK_LEN   (BLANK_CYCLES),
    .DISPLAY_LEN (DISPLAY_CYCLES)
  ) u_slotTimer (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_displaySel (state == ST_DISPLAY),
    .o_lastCycle  (lastCycle)
  );

  always_comb begin
    stateNext       = state;
    posNext         = pos;
    advance         = 1'b0;
    shadowValueNext = shadowValue;
    shadowDpNext    = shadowDp;
    shadowEnNext    = shadowEn;
    if (lastCycle) begin
      if (state == ST_BLANK) begin
        advance   = 1'b1;
        stateNext = ST_DISPLAY;
      end else if (BLANK_CYCLES == 0) begin
        advance = 1'b1;
      end else begin
        stateNext = ST_BLANK;
      end
    end
    if (advance) begin
      posNext = pos + 1'b1;
    end
    wrap = advance && (pos == POS_W'(DIGIT_COUNT - 1));
    // A load landing on the wrap cycle goes straight to the new frame.
    if (wrap) begin
      shadowValueNext = i_load ? i_value   : pendValue;
      shadowDpNext    = i_load ? i_dpMask  : pendDp;
      shadowEnNext    = i_load ? i_digitEn : pendEn;
    end
  end

  // Position k is a leading zero when nibbles k..3 are zero and no dp is lit at or above it.
  for (genvar gi = 0; gi < DIGIT_COUNT; gi++) begin : gSup
    if (gi == 0 || LZ_SUPPRESS == 0) begin : gNone
      assign supNext[gi] = 1'b0;
    end else begin : gLz
      assign supNext[gi] = (shadowValueNext[WORD_W-1:NIBBLE_W*gi] == '0) &&
                           (shadowDpNext[DIGIT_COUNT-1:gi] == '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ST_BLANK;
      pos          <= POS_W'(DIGIT_COUNT - 1);
      pendValue    <= '0;
      pendDp       <= '0;
      pendEn       <= '1;
      shadowValue  <= '0;
      shadowDp     <= '0;
      shadowEn     <= '1;
      o_digitValue <= '0;
      o_dp         <= 1'b0;
      o_blank      <= 1'b1;
      o_frameStart <= 1'b0;
    end else begin
      state       <= stateNext;
      pos         <= posNext;
      shadowValue <= shadowValueNext;
      shadowDp    <= shadowDpNext;
      shadowEn    <= shadowEnNext;
      if (i_load) begin
        pendValue <= i_value;
        pendDp    <= i_dpMask;
        pendEn    <= i_digitEn;
      end
      o_digitValue <= shadowValueNext[NIBBLE_W*posNext +: NIBBLE_W];
      o_dp         <= shadowDpNext[posNext];
      o_blank      <= (stateNext == ST_BLANK) | ~shadowEnNext[posNext] | supNext[posNext];
      o_frameStart <= wrap;
    end
  end

  assign o_digitPosion = pos;

endmodule
